// File: rtl/fnd_mux_ctrl.sv
// Multiplexed common-anode 7-segment scanner: tear-free frame-aligned load,
// leading-zero blanking, 16-step PWM brightness and a frame-done strobe.
module fnd_mux_ctrl #(
    parameter int DIGITS   = 4,
    parameter int DIV_BITS = 17
) (
    input  logic                  clk,
    input  logic                  reset_p,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic [3:0]            brightness,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     com,
    output logic                  frame_done
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    logic [DIV_BITS-1:0] presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] pend_val_q, pend_val_d, shad_val_q, shad_val_d;
    logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, shad_dp_q, shad_dp_d;
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   com_q, com_d;
    logic                fd_q, fd_d;

    logic                tick, wrap, lit, run;
    logic [3:0]          phase, nib;
    logic [DIGITS-1:0]   lz;

    always_comb begin
        presc_d = presc_q + 1'b1;
        tick    = &presc_q;
        wrap    = tick && (idx_q == IW'(DIGITS-1));
        idx_d   = idx_q;
        if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;
        fd_d    = wrap;

        pend_val_d = load ? value : pend_val_q;
        pend_dp_d  = load ? dp    : pend_dp_q;
        // Shadow only moves on the wrapping tick; a coincident load bypasses pending.
        shad_val_d = wrap ? pend_val_d : shad_val_q;
        shad_dp_d  = wrap ? pend_dp_d  : shad_dp_q;

        // lz[i]: all nibbles from the top down to i are zero.
        run = 1'b1;
        lz  = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run   = run && (shad_val_q[4*i +: 4] == 4'h0);
            lz[i] = run;
        end

        phase = presc_q[DIV_BITS-1 -: 4];
        nib   = shad_val_q[{idx_q, 2'b00} +: 4];
        lit   = (phase < brightness) && !(blank_lz && (idx_q != '0) && lz[idx_q]);

        seg_d = 8'hFF;
        com_d = '1;
        if (lit) begin
            com_d[idx_q] = 1'b0;
            seg_d        = {~shad_dp_q[idx_q], hex7(nib)};
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            presc_q    <= '0;
            idx_q      <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            shad_val_q <= '0;
            shad_dp_q  <= '0;
            seg_q      <= 8'hFF;
            com_q      <= '1;
            fd_q       <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            shad_val_q <= shad_val_d;
            shad_dp_q  <= shad_dp_d;
            seg_q      <= seg_d;
            com_q      <= com_d;
            fd_q       <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign com        = com_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_fnd_mux_ctrl.sv
// Scoreboard bench: stimulus queues per-frame expectations, a monitor checks
// each queued frame after frame_done; a second instance covers 8 digits.
module tb_fnd_mux_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_p = 1'b1;

    logic [15:0] value4 = '0;
    logic [3:0]  dp4 = '0, bright4 = 4'd15;
    logic        load4 = 1'b0, blank4 = 1'b0;
    logic [7:0]  seg4;
    logic [3:0]  com4;
    logic        fd4;

    logic [31:0] value8 = '0;
    logic [7:0]  dp8 = '0;
    logic        load8 = 1'b0, blank8 = 1'b0;
    logic [3:0]  bright8 = 4'd15;
    logic [7:0]  seg8, com8;
    logic        fd8;
    logic        done8 = 1'b0;

    fnd_mux_ctrl #(.DIGITS(4), .DIV_BITS(5)) u_dut4 (
        .clk(clk), .reset_p(reset_p), .value(value4), .dp(dp4), .load(load4),
        .blank_lz(blank4), .brightness(bright4), .seg(seg4), .com(com4), .frame_done(fd4));

    fnd_mux_ctrl #(.DIGITS(8), .DIV_BITS(6)) u_dut8 (
        .clk(clk), .reset_p(reset_p), .value(value8), .dp(dp8), .load(load8),
        .blank_lz(blank8), .brightness(bright8), .seg(seg8), .com(com8), .frame_done(fd8));

    localparam logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    typedef struct {
        logic [3:0][3:0] com;
        logic [3:0][7:0] seg;
        int              off;   // prescaler count within each slot at which to sample
        string           tag;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] v, input logic [3:0] d, input logic blank,
                                input logic dark, input int off, input string tag);
        exp_t e;
        logic [7:0] h;
        for (int k = 0; k < 4; k++) begin
            h = HEX[v[4*k +: 4]];
            if (dark || (blank && k > 0 && (v >> (4*k)) == 16'h0)) begin
                e.com[k] = 4'hF;
                e.seg[k] = 8'hFF;
            end else begin
                e.com[k] = ~(4'b0001 << k);
                e.seg[k] = {~d[k], h[6:0]};
            end
        end
        e.off = off;
        e.tag = tag;
        return e;
    endfunction

    task automatic push(input exp_t e);
        #1 sb.push_back(e);
    endtask

    task automatic next_frame();
        int n = 0;
        do begin @(negedge clk); n++; end while (!fd4 && n < 300);
        if (!fd4) chk("frame_done timeout", 32'(fd4), 32'd1);
    endtask

    // Monitor: on each frame_done with a pending expectation, sample every digit slot.
    initial begin
        exp_t e;
        int cnt;
        forever begin
            @(negedge clk);
            if (fd4 && sb.size() > 0) begin
                e = sb.pop_front();
                cnt = 0;
                for (int k = 0; k < 4; k++) begin
                    repeat (k*32 + e.off + 1 - cnt) @(posedge clk);
                    cnt = k*32 + e.off + 1;
                    @(negedge clk);
                    chk($sformatf("%s com d%0d", e.tag, k), 32'(com4), 32'(e.com[k]));
                    chk($sformatf("%s seg d%0d", e.tag, k), 32'(seg4), 32'(e.seg[k]));
                end
            end
        end
    end

    task automatic dut8_check();
        int n, cnt;
        logic [7:0] ec;
        n = 0;
        do begin @(negedge clk); n++; end while (!fd8 && n < 1200);
        if (!fd8) chk("dut8 frame_done timeout", 32'(fd8), 32'd1);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            repeat (k*64 + 2 - cnt) @(posedge clk);
            cnt = k*64 + 2;
            @(negedge clk);
            ec = 8'h01 << k;
            ec = ~ec;
            chk($sformatf("dut8 com d%0d", k), 32'(com8), 32'(ec));
            chk($sformatf("dut8 seg d%0d", k), 32'(seg8), 32'h00C0);
        end
        n = cnt;
        do begin @(negedge clk); n++; end while (!fd8 && n < 700);
        chk("dut8 frame period", n, 512);
        done8 = 1'b1;
    endtask

    initial begin
        exp_t ra;
        int n;
        repeat (3) @(negedge clk);
        chk("reset seg", 32'(seg4), 32'h00FF);
        chk("reset com", 32'(com4), 32'h000F);
        chk("reset frame_done", 32'(fd4), 32'd0);
        chk("reset com8", 32'(com8), 32'h00FF);
        reset_p = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("post-reset d0 com", 32'(com4), 32'hE);
        chk("post-reset d0 seg", 32'(seg4), 32'hC0);
        fork dut8_check(); join_none

        // Frame 0: load 12AF, visible from frame 1
        load4 = 1'b1; value4 = 16'h12AF; dp4 = 4'b0000;
        @(negedge clk) load4 = 1'b0;
        ra.com = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
        ra.seg = {8'hF9, 8'hA4, 8'h88, 8'h8E};
        ra.off = 1;
        ra.tag = "basic 12AF";
        push(ra);

        next_frame();                               // frame 1
        push(mk(16'h12AF, 4'h0, 1'b0, 1'b0, 1, "tear old"));
        push(mk(16'h1234, 4'h0, 1'b0, 1'b0, 1, "tear new"));

        next_frame();                               // frame 2: mid-frame load
        repeat (40) @(posedge clk);
        @(negedge clk) begin load4 = 1'b1; value4 = 16'h1234; end
        @(negedge clk) load4 = 1'b0;

        next_frame();                               // frame 3: pulse width + period
        @(negedge clk);
        chk("frame_done width", 32'(fd4), 32'd0);
        n = 1;
        do begin @(negedge clk); n++; end while (!fd4 && n < 300);
        chk("frame period", n, 128);

        // Frame 4: load coincident with wrapping tick goes straight to shadow
        push(mk(16'h9876, 4'h0, 1'b0, 1'b0, 1, "bypass"));
        repeat (127) @(posedge clk);
        @(negedge clk) begin load4 = 1'b1; value4 = 16'h9876; end
        @(negedge clk) load4 = 1'b0;
        chk("frame_done after bypass wrap", 32'(fd4), 32'd1);

        repeat (10) @(posedge clk);                 // frame 5
        @(negedge clk) begin load4 = 1'b1; value4 = 16'h0050; blank4 = 1'b1; end
        @(negedge clk) load4 = 1'b0;
        push(mk(16'h0050, 4'h0, 1'b1, 1'b0, 1, "blank 0050"));

        next_frame();                               // frame 6
        repeat (10) @(posedge clk);
        @(negedge clk) begin load4 = 1'b1; value4 = 16'h0000; end
        @(negedge clk) load4 = 1'b0;
        push(mk(16'h0000, 4'h0, 1'b1, 1'b0, 1, "blank 0000"));

        next_frame();                               // frame 7
        repeat (10) @(posedge clk);
        @(negedge clk) begin load4 = 1'b1; value4 = 16'h1234; dp4 = 4'b0100; end
        @(negedge clk) load4 = 1'b0;
        push(mk(16'h1234, 4'b0100, 1'b1, 1'b0, 1, "dp"));

        next_frame();                               // frame 8
        bright4 = 4'd4;
        push(mk(16'h1234, 4'b0100, 1'b1, 1'b0, 7, "pwm4 on"));
        push(mk(16'h1234, 4'b0100, 1'b1, 1'b1, 9, "pwm4 off"));

        next_frame();                               // frame 9
        next_frame();                               // frame 10
        bright4 = 4'd0;
        push(mk(16'h1234, 4'b0100, 1'b1, 1'b1, 1, "pwm0"));

        next_frame();                               // frame 11
        push(mk(16'h1234, 4'b0100, 1'b1, 1'b1, 30, "pwm15 phase15"));
        push(mk(16'h1234, 4'b0100, 1'b1, 1'b0, 29, "pwm15 phase14"));
        repeat (110) @(posedge clk);
        @(negedge clk) bright4 = 4'd15;

        next_frame();                               // frame 12
        next_frame();                               // frame 13
        next_frame();                               // frame 14
        chk("scoreboard drained", sb.size(), 0);
        chk("dut8 sweep done", 32'(done8), 32'd1);

        // Asynchronous reset mid-slot
        blank4 = 1'b0;
        repeat (50) @(posedge clk);
        #3 reset_p = 1'b1;
        #1;
        chk("async reset seg", 32'(seg4), 32'h00FF);
        chk("async reset com", 32'(com4), 32'h000F);
        chk("async reset frame_done", 32'(fd4), 32'd0);
        @(negedge clk);
        @(negedge clk) reset_p = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("restart d0 com", 32'(com4), 32'hE);
        chk("restart d0 seg", 32'(seg4), 32'hC0);
        push(mk(16'h0000, 4'h0, 1'b0, 1'b0, 1, "zero after reset"));
        next_frame();
        next_frame();
        chk("scoreboard drained end", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
